// File: rtl/eth_rx2_if.sv
// eth_rx2_if -- receive-side buffer write port and frame status bundle.
//
// Groups everything the Manchester receiver hands to the rest of the MAC:
//   w_addr[7:0]      byte address in the external receive buffer (index mod 256)
//   w_data[7:0]      received byte
//   w_en             one-cycle buffer write strobe
//   rx_busy          receiver is inside a preamble or a frame body
//   frame_valid      one-cycle end-of-frame strobe
//   frame_len[10:0]  complete bytes of the last frame (FCS included), saturating
//   crc_ok           last frame's FCS checked good
//   overflow         last frame was longer than the 256-byte buffer
//
// master: the receiver drives the bundle. slave: the buffer/MAC consumes it.
interface eth_rx2_if;
    logic [7:0]  w_addr;
    logic [7:0]  w_data;
    logic        w_en;
    logic        rx_busy;
    logic        frame_valid;
    logic [10:0] frame_len;
    logic        crc_ok;
    logic        overflow;

    modport master (
        output w_addr, w_data, w_en, rx_busy,
        output frame_valid, frame_len, crc_ok, overflow
    );

    modport slave (
        input  w_addr, w_data, w_en, rx_busy,
        input  frame_valid, frame_len, crc_ok, overflow
    );
endinterface

// File: rtl/eth_rx2.sv
// eth_rx2 -- 10BASE-T Manchester receiver.
//
// Oversamples the differential receiver output, recovers bit timing from the
// mid-bit transitions, hunts for an alternating preamble followed by the SFD,
// then deserialises the frame LSB-first into an external byte buffer and
// checks the FCS by comparing the CRC-32 register against the fixed residue.
//
// Ports:
//   clk    in   system clock (HALF_BIT cycles per Manchester half-bit)
//   rst_n  in   asynchronous active-low reset
//   rx_p   in   asynchronous line level; idle low, link pulses high
//   bus    eth_rx2_if.master: buffer write port and frame status outputs
//
// Parameters:
//   HALF_BIT  clk cycles per half-bit; even and >= 4
//   MIN_PRE   alternating preamble bits required before the SFD is honoured
module eth_rx2 #(
    parameter int HALF_BIT = 4,
    parameter int MIN_PRE  = 16
) (
    input  logic      clk,
    input  logic      rst_n,
    input  logic      rx_p,
    eth_rx2_if.master bus
);

    // Edge-timer limits: carrier is lost after 1.5 bit times without a
    // mid-bit edge; anything earlier than 3/4 of a bit is a boundary edge.
    localparam int LOSS     = 3 * HALF_BIT;
    localparam int EDGE_MIN = (3 * HALF_BIT) / 2;
    localparam int CNT_W    = $clog2(LOSS + 1);
    localparam int PRE_W    = $clog2(MIN_PRE + 1);

    localparam logic [CNT_W-1:0] LOSS_C     = CNT_W'(LOSS);
    localparam logic [CNT_W-1:0] EDGE_MIN_C = CNT_W'(EDGE_MIN);
    localparam logic [PRE_W-1:0] MIN_PRE_C  = PRE_W'(MIN_PRE);

    localparam logic [31:0] CRC_POLY    = 32'h04C1_1DB7;
    localparam logic [31:0] CRC_INIT    = 32'hFFFF_FFFF;
    localparam logic [31:0] CRC_RESIDUE = 32'hC704_DD7B;
    localparam logic [10:0] LEN_MAX     = 11'd2047;
    localparam logic [10:0] BUF_BYTES   = 11'd256;
    localparam logic [10:0] FCS_BYTES   = 11'd4;

    typedef enum logic [2:0] {
        ST_HUNT = 3'd0,
        ST_PRE  = 3'd1,
        ST_DATA = 3'd2,
        ST_END  = 3'd3,
        ST_DROP = 3'd4
    } state_t;

    // CRC-32 over one byte, bits taken LSB-first into an MSB-first register.
    // Updating once per completed byte keeps dribble bits out of the CRC.
    function automatic logic [31:0] crc32_byte(input logic [31:0] crc_in,
                                               input logic [7:0]  data_in);
        logic [31:0] crc_v;
        crc_v = crc_in;
        for (int i = 0; i < 8; i++) begin
            if ((data_in[i] ^ crc_v[31]) == 1'b1) begin
                crc_v = {crc_v[30:0], 1'b0} ^ CRC_POLY;
            end else begin
                crc_v = {crc_v[30:0], 1'b0};
            end
        end
        return crc_v;
    endfunction

    state_t           state_r;
    state_t           state_nx;

    logic             sync1_r;
    logic             sync2_r;
    logic             lvl_r;
    logic [CNT_W-1:0] cnt_r;

    logic             prev_bit_r;
    logic [PRE_W-1:0] pre_cnt_r;
    logic [6:0]       shift_r;
    logic [2:0]       bit_cnt_r;
    logic [10:0]      byte_cnt_r;
    logic [31:0]      crc_r;
    logic             ovf_r;

    logic [7:0]       w_addr_r;
    logic [7:0]       w_data_r;
    logic             w_en_r;
    logic             rx_busy_r;
    logic             frame_valid_r;
    logic [10:0]      frame_len_r;
    logic             crc_ok_r;
    logic             overflow_r;

    logic             edge_s;
    logic             loss_s;
    logic             accept_s;
    logic             bit_s;
    logic             alt_s;
    logic [7:0]       byte_s;

    // The decoded bit is the level the line moved to; an edge is any change
    // of the synchronised level against the previous cycle's level.
    assign bit_s  = sync2_r;
    assign edge_s = sync2_r ^ lvl_r;
    assign loss_s = (cnt_r == LOSS_C);
    assign alt_s  = (bit_s != prev_bit_r);
    assign byte_s = {bit_s, shift_r};

    // Edge qualification: in HUNT any edge sets the phase; elsewhere only
    // edges late enough to be mid-bit count, and carrier loss wins a tie.
    always_comb begin
        accept_s = 1'b0;
        case (state_r)
            ST_HUNT: begin
                accept_s = edge_s;
            end
            ST_PRE, ST_DATA, ST_DROP: begin
                if (edge_s && (cnt_r >= EDGE_MIN_C) && !loss_s) begin
                    accept_s = 1'b1;
                end else begin
                    accept_s = 1'b0;
                end
            end
            ST_END: begin
                accept_s = 1'b0;
            end
            default: begin
                accept_s = 1'b0;
            end
        endcase
    end

    // Next-state logic for the frame hunter.
    always_comb begin
        state_nx = state_r;
        case (state_r)
            ST_HUNT: begin
                if (accept_s) begin
                    state_nx = ST_PRE;
                end else begin
                    state_nx = ST_HUNT;
                end
            end
            ST_PRE: begin
                if (loss_s) begin
                    state_nx = ST_HUNT;
                end else if (accept_s) begin
                    if (alt_s) begin
                        state_nx = ST_PRE;
                    end else if (bit_s && (pre_cnt_r >= MIN_PRE_C)) begin
                        // "11" after enough preamble is the end of the SFD
                        state_nx = ST_DATA;
                    end else begin
                        state_nx = ST_DROP;
                    end
                end else begin
                    state_nx = ST_PRE;
                end
            end
            ST_DATA: begin
                if (loss_s) begin
                    state_nx = ST_END;
                end else begin
                    state_nx = ST_DATA;
                end
            end
            ST_END: begin
                state_nx = ST_HUNT;
            end
            ST_DROP: begin
                if (loss_s) begin
                    state_nx = ST_HUNT;
                end else begin
                    state_nx = ST_DROP;
                end
            end
            default: begin
                state_nx = ST_HUNT;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_HUNT;
        end else begin
            state_r <= state_nx;
        end
    end

    // Line synchroniser, edge-detect level and saturating edge timer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_r <= 1'b0;
            sync2_r <= 1'b0;
            lvl_r   <= 1'b0;
            cnt_r   <= '0;
        end else begin
            sync1_r <= rx_p;
            sync2_r <= sync1_r;
            lvl_r   <= sync2_r;
            if (accept_s) begin
                cnt_r <= '0;
            end else if (cnt_r != LOSS_C) begin
                cnt_r <= cnt_r + 1'b1;
            end
        end
    end

    // Preamble counting, deserialiser, CRC and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_bit_r    <= 1'b0;
            pre_cnt_r     <= '0;
            shift_r       <= 7'd0;
            bit_cnt_r     <= 3'd0;
            byte_cnt_r    <= 11'd0;
            crc_r         <= 32'd0;
            ovf_r         <= 1'b0;
            w_addr_r      <= 8'd0;
            w_data_r      <= 8'd0;
            w_en_r        <= 1'b0;
            rx_busy_r     <= 1'b0;
            frame_valid_r <= 1'b0;
            frame_len_r   <= 11'd0;
            crc_ok_r      <= 1'b0;
            overflow_r    <= 1'b0;
        end else begin
            w_en_r        <= 1'b0;
            frame_valid_r <= 1'b0;
            rx_busy_r     <= (state_nx == ST_PRE) || (state_nx == ST_DATA);
            case (state_r)
                ST_HUNT: begin
                    if (accept_s) begin
                        // the phase edge's level seeds the alternation check
                        prev_bit_r <= bit_s;
                        pre_cnt_r  <= '0;
                    end
                end
                ST_PRE: begin
                    if (accept_s) begin
                        prev_bit_r <= bit_s;
                        if (alt_s && (pre_cnt_r != MIN_PRE_C)) begin
                            pre_cnt_r <= pre_cnt_r + 1'b1;
                        end
                        if (state_nx == ST_DATA) begin
                            crc_r      <= CRC_INIT;
                            shift_r    <= 7'd0;
                            bit_cnt_r  <= 3'd0;
                            byte_cnt_r <= 11'd0;
                            ovf_r      <= 1'b0;
                        end
                    end
                end
                ST_DATA: begin
                    if (loss_s) begin
                        // partial bits left in shift_r are simply abandoned
                        frame_valid_r <= 1'b1;
                        frame_len_r   <= byte_cnt_r;
                        crc_ok_r      <= (crc_r == CRC_RESIDUE) &&
                                         (byte_cnt_r >= FCS_BYTES);
                        overflow_r    <= ovf_r;
                    end else if (accept_s) begin
                        shift_r   <= byte_s[7:1];
                        bit_cnt_r <= bit_cnt_r + 3'd1;
                        if (bit_cnt_r == 3'd7) begin
                            crc_r <= crc32_byte(crc_r, byte_s);
                            if (byte_cnt_r >= BUF_BYTES) begin
                                ovf_r <= 1'b1;
                            end else begin
                                w_en_r   <= 1'b1;
                                w_addr_r <= byte_cnt_r[7:0];
                                w_data_r <= byte_s;
                            end
                            if (byte_cnt_r != LEN_MAX) begin
                                byte_cnt_r <= byte_cnt_r + 11'd1;
                            end
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign bus.w_addr      = w_addr_r;
    assign bus.w_data      = w_data_r;
    assign bus.w_en        = w_en_r;
    assign bus.rx_busy     = rx_busy_r;
    assign bus.frame_valid = frame_valid_r;
    assign bus.frame_len   = frame_len_r;
    assign bus.crc_ok      = crc_ok_r;
    assign bus.overflow    = overflow_r;

endmodule

// File: tb/tb_eth_rx2.sv
// tb_eth_rx2 -- directed testbench for eth_rx2.
//
// Frames are built as byte lists, Manchester-encoded onto rx_p, and a
// transaction-level model (byte list -> expected writes and end-of-frame
// status, reflected CRC-32 for the FCS) feeds queues that one compare
// process checks against the DUT after every rising clock edge.
module tb_eth_rx2;

    localparam int          HB           = 4;
    localparam logic [31:0] RESIDUE_REFL = 32'hDEBB_20E3;

    logic clk;
    logic rst_n;
    logic rx_p;

    eth_rx2_if bus ();

    eth_rx2 #(.HALF_BIT(HB), .MIN_PRE(16)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .rx_p  (rx_p),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          vectors     = 0;
    int          miscompares = 0;
    int          wr_seen     = 0;
    int          st_seen     = 0;
    logic [15:0] exp_wr_q[$];
    logic [12:0] exp_st_q[$];
    logic [10:0] held_len = 11'd0;
    logic        held_crc = 1'b0;
    logic        held_ovf = 1'b0;
    logic [7:0]  frame_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
        end
    endtask

    // Reflected CRC-32 over frame_q, without the final inversion.
    function automatic logic [31:0] crc_run();
        logic [31:0] c;
        c = 32'hFFFF_FFFF;
        foreach (frame_q[i]) begin
            c = c ^ {24'd0, frame_q[i]};
            for (int k = 0; k < 8; k++) begin
                if (c[0]) c = (c >> 1) ^ 32'hEDB8_8320;
                else      c = c >> 1;
            end
        end
        return c;
    endfunction

    task automatic build_payload(input int n);
        frame_q.delete();
        for (int i = 0; i < n; i++) frame_q.push_back(i[7:0]);
    endtask

    task automatic append_fcs();
        logic [31:0] c;
        c = ~crc_run();
        frame_q.push_back(c[7:0]);
        frame_q.push_back(c[15:8]);
        frame_q.push_back(c[23:16]);
        frame_q.push_back(c[31:24]);
    endtask

    // Model: what the receiver must report for the bytes in frame_q.
    task automatic expect_frame(output logic crc_m, output int nwr);
        int          n;
        logic [10:0] len;
        logic        ovf;
        n   = frame_q.size();
        nwr = 0;
        for (int i = 0; i < n && i < 256; i++) begin
            exp_wr_q.push_back({i[7:0], frame_q[i]});
            nwr++;
        end
        len   = (n > 2047) ? 11'd2047 : n[10:0];
        crc_m = (crc_run() == RESIDUE_REFL) && (n >= 4);
        ovf   = (n > 256);
        exp_st_q.push_back({len, crc_m, ovf});
    endtask

    // Manchester: bit 1 is low then high, bit 0 is high then low.
    task automatic send_bit(input logic b);
        rx_p = ~b;
        repeat (HB) @(negedge clk);
        rx_p = b;
        repeat (HB) @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] b);
        for (int i = 0; i < 8; i++) send_bit(b[i]);
    endtask

    task automatic send_frame(input int n_pre, input int n_drib, input logic [7:0] drib);
        for (int p = 0; p < n_pre; p++) send_byte(8'h55);
        send_byte(8'hD5);
        foreach (frame_q[i]) send_byte(frame_q[i]);
        for (int d = 0; d < n_drib; d++) send_bit(drib[d]);
        repeat (30) @(negedge clk);
        rx_p = 1'b0;
        repeat (30) @(negedge clk);
    endtask

    // Compare process: every cycle, after the rising edge.
    initial begin : compare
        logic [15:0] e;
        logic [12:0] s;
        forever begin
            @(posedge clk);
            #1;
            check("wen_fv_exclusive", {31'd0, bus.w_en & bus.frame_valid}, 32'd0);
            if (bus.w_en) begin
                wr_seen++;
                check("write_expected", {31'd0, exp_wr_q.size() != 0}, 32'd1);
                if (exp_wr_q.size() != 0) begin
                    e = exp_wr_q.pop_front();
                    check("write_addr", {24'd0, bus.w_addr}, {24'd0, e[15:8]});
                    check("write_data", {24'd0, bus.w_data}, {24'd0, e[7:0]});
                end
            end
            if (bus.frame_valid) begin
                st_seen++;
                check("status_expected", {31'd0, exp_st_q.size() != 0}, 32'd1);
                if (exp_st_q.size() != 0) begin
                    s        = exp_st_q.pop_front();
                    held_len = s[12:2];
                    held_crc = s[1];
                    held_ovf = s[0];
                end
            end
            check("frame_len", {21'd0, bus.frame_len}, {21'd0, held_len});
            check("crc_ok", {31'd0, bus.crc_ok}, {31'd0, held_crc});
            check("overflow", {31'd0, bus.overflow}, {31'd0, held_ovf});
            if (!rst_n) begin
                check("outputs_in_reset", {29'd0, bus.w_en, bus.frame_valid, bus.rx_busy}, 32'd0);
            end
        end
    end

    initial begin : stim
        logic  crc_m;
        int    nwr;
        int    wr0;
        int    st0;
        string s9;

        rst_n = 1'b1;
        rx_p  = 1'b0;
        #1 rst_n = 1'b0;

        // Reset held while the line toggles.
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            rx_p = i[1];
        end
        @(posedge clk);
        #1;
        check("reset_state", {bus.frame_len, bus.w_en, bus.frame_valid, bus.rx_busy,
                              bus.crc_ok, bus.overflow}, 32'd0);
        @(negedge clk);
        rx_p = 1'b0;
        repeat (20) @(negedge clk);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);

        // Pin the model CRC to known literals.
        s9 = "123456789";
        frame_q.delete();
        for (int i = 0; i < 9; i++) frame_q.push_back(s9[i]);
        check("model_check_value", ~crc_run(), 32'hCBF4_3926);

        // Good frame: 60 payload bytes plus FCS.
        build_payload(60);
        append_fcs();
        check("model_residue", crc_run(), RESIDUE_REFL);
        expect_frame(crc_m, nwr);
        check("model_good_crc", {31'd0, crc_m}, 32'd1);
        check("model_good_writes", nwr, 32'd64);
        wr0 = wr_seen;
        st0 = st_seen;
        send_frame(7, 0, 8'h00);
        check("good_write_count", wr_seen - wr0, 32'd64);
        check("good_status_count", st_seen - st0, 32'd1);
        check("good_drained", exp_wr_q.size() + exp_st_q.size(), 32'd0);

        // Same frame with one payload bit inverted.
        build_payload(60);
        append_fcs();
        frame_q[20] = frame_q[20] ^ 8'h10;
        expect_frame(crc_m, nwr);
        check("model_bad_crc", {31'd0, crc_m}, 32'd0);
        wr0 = wr_seen;
        st0 = st_seen;
        send_frame(7, 0, 8'h00);
        check("bad_write_count", wr_seen - wr0, 32'd64);
        check("bad_status_count", st_seen - st0, 32'd1);

        // Only 8 preamble bits before the SFD: nothing may come out.
        build_payload(60);
        append_fcs();
        wr0 = wr_seen;
        st0 = st_seen;
        send_frame(1, 0, 8'h00);
        check("shortpre_writes", wr_seen - wr0, 32'd0);
        check("shortpre_status", st_seen - st0, 32'd0);

        // Link pulses: one bit time high, long idle between.
        wr0 = wr_seen;
        st0 = st_seen;
        for (int p = 0; p < 4; p++) begin
            @(negedge clk);
            rx_p = 1'b1;
            repeat (2 * HB) @(negedge clk);
            rx_p = 1'b0;
            repeat (1000) @(negedge clk);
            @(posedge clk);
            #1;
            check("link_busy_idle", {31'd0, bus.rx_busy}, 32'd0);
        end
        @(negedge clk);
        check("link_writes", wr_seen - wr0, 32'd0);
        check("link_status", st_seen - st0, 32'd0);

        // 300-byte frame with valid FCS plus 3 dribble bits.
        build_payload(296);
        append_fcs();
        check("model_long_len", frame_q.size(), 32'd300);
        expect_frame(crc_m, nwr);
        check("model_long_writes", nwr, 32'd256);
        wr0 = wr_seen;
        st0 = st_seen;
        send_frame(7, 3, 8'h05);
        check("long_write_count", wr_seen - wr0, 32'd256);
        check("long_status_count", st_seen - st0, 32'd1);
        check("long_drained", exp_wr_q.size() + exp_st_q.size(), 32'd0);

        // Reset in the middle of the payload: no status strobe.
        build_payload(60);
        append_fcs();
        expect_frame(crc_m, nwr);
        wr0 = wr_seen;
        st0 = st_seen;
        fork
            send_frame(7, 0, 8'h00);
            begin
                repeat (512 + 20 * 64) @(negedge clk);
                rst_n = 1'b0;
                exp_wr_q.delete();
                exp_st_q.delete();
                held_len = 11'd0;
                held_crc = 1'b0;
                held_ovf = 1'b0;
                repeat (4) @(negedge clk);
                rst_n = 1'b1;
            end
        join
        check("midreset_status", st_seen - st0, 32'd0);
        check("midreset_partial_writes",
              {31'd0, (wr_seen - wr0 >= 15) && (wr_seen - wr0 <= 25)}, 32'd1);

        // A good frame right after still decodes.
        build_payload(60);
        append_fcs();
        expect_frame(crc_m, nwr);
        wr0 = wr_seen;
        st0 = st_seen;
        send_frame(7, 0, 8'h00);
        check("after_reset_writes", wr_seen - wr0, 32'd64);
        check("after_reset_status", st_seen - st0, 32'd1);
        check("final_drained", exp_wr_q.size() + exp_st_q.size(), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
